// File: rtl/mem_access_sequencer.sv
// MEM-stage sequencer: issues one req/ack data-memory access per load/store, stalling upstream until it completes.
// Stall covers the IDLE issue cycle plus every WAIT cycle; a watchdog aborts an access after TIMEOUT unacked cycles.
module mem_access_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        Load_In,
    input  logic        Store_In,
    input  logic [31:0] Addr_In,
    input  logic [31:0] Wdata_In,
    input  logic        Err_Clr,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_Rdata,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic [31:0] Mem_Addr,
    output logic [31:0] Mem_Wdata,
    output logic        Stall,
    output logic        Wb_Bubble,
    output logic [31:0] Data_Mem_Out,
    output logic        Err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          mem_op;
    logic          timeout_hit;

    assign mem_op = Load_In | Store_In;

    // Ack wins over the watchdog when both land in the final WAIT cycle.
    assign timeout_hit = (state == S_WAIT) && !Mem_Ack && (wait_cnt == LAST_WAIT);

    assign Stall     = !CLR && (((state == S_IDLE) && mem_op) || (state == S_WAIT));
    assign Wb_Bubble = Stall;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            Mem_Req      <= 1'b0;
            Mem_We       <= 1'b0;
            Mem_Addr     <= '0;
            Mem_Wdata    <= '0;
            Data_Mem_Out <= '0;
            Err          <= 1'b0;
        end else begin
            if (timeout_hit) begin
                Err <= 1'b1;
            end else if (Err_Clr) begin
                Err <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (mem_op) begin
                        Mem_Addr  <= Addr_In;
                        Mem_Wdata <= Wdata_In;
                        Mem_We    <= Store_In & ~Load_In;
                        Mem_Req   <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (Mem_Ack) begin
                        if (!Mem_We) begin
                            Data_Mem_Out <= Mem_Rdata;
                        end
                        Mem_Req <= 1'b0;
                        state   <= S_DONE;
                    end else if (timeout_hit) begin
                        Data_Mem_Out <= '0;
                        Mem_Req      <= 1'b0;
                        state        <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomised and directed bench for mem_access_sequencer against an access-level reference model.
module tb_mem_access_sequencer;

    localparam int TIMEOUT = 4;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        Load_In = 1'b0;
    logic        Store_In = 1'b0;
    logic [31:0] Addr_In = '0;
    logic [31:0] Wdata_In = '0;
    logic        Err_Clr = 1'b0;
    logic        Mem_Ack = 1'b0;
    logic [31:0] Mem_Rdata = '0;
    logic        Mem_Req;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_Wdata;
    logic        Stall;
    logic        Wb_Bubble;
    logic [31:0] Data_Mem_Out;
    logic        Err;

    mem_access_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .CLK          (CLK),
        .CLR          (CLR),
        .Load_In      (Load_In),
        .Store_In     (Store_In),
        .Addr_In      (Addr_In),
        .Wdata_In     (Wdata_In),
        .Err_Clr      (Err_Clr),
        .Mem_Ack      (Mem_Ack),
        .Mem_Rdata    (Mem_Rdata),
        .Mem_Req      (Mem_Req),
        .Mem_We       (Mem_We),
        .Mem_Addr     (Mem_Addr),
        .Mem_Wdata    (Mem_Wdata),
        .Stall        (Stall),
        .Wb_Bubble    (Wb_Bubble),
        .Data_Mem_Out (Data_Mem_Out),
        .Err          (Err)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: an access is "outstanding" for a number of elapsed WAIT cycles,
    // then spends exactly one completion cycle before the next op may be accepted.
    bit          outstanding = 0;
    bit          completing  = 0;
    int          waited      = 0;
    bit          r_req = 0, r_we = 0, r_err = 0;
    logic [31:0] r_addr = '0, r_wdata = '0, r_dout = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_stall();
        bit op;
        op = Load_In | Store_In;
        if (CLR) return 1'b0;
        if (outstanding) return 1'b1;
        return !completing && op;
    endfunction

    task automatic model_edge();
        bit timed_out;
        timed_out = 0;
        if (CLR) begin
            outstanding = 0; completing = 0; waited = 0;
            r_req = 0; r_we = 0; r_err = 0;
            r_addr = '0; r_wdata = '0; r_dout = '0;
            return;
        end
        if (completing) begin
            completing = 0;
        end else if (outstanding) begin
            waited = waited + 1;
            if (Mem_Ack) begin
                if (!r_we) r_dout = Mem_Rdata;
                outstanding = 0; completing = 1; r_req = 0;
            end else if (waited == TIMEOUT) begin
                r_dout = '0; timed_out = 1;
                outstanding = 0; completing = 1; r_req = 0;
            end
        end else if (Load_In || Store_In) begin
            r_addr = Addr_In; r_wdata = Wdata_In;
            r_we = Store_In && !Load_In;
            r_req = 1; outstanding = 1; waited = 0;
        end
        r_err = timed_out ? 1'b1 : (Err_Clr ? 1'b0 : r_err);
    endtask

    task automatic step(input logic clr, input logic ld, input logic st,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic ack, input logic [31:0] rd, input logic eclr);
        @(negedge CLK);
        CLR = clr; Load_In = ld; Store_In = st; Addr_In = addr; Wdata_In = wd;
        Mem_Ack = ack; Mem_Rdata = rd; Err_Clr = eclr;
        #1;
        check("req",    {31'd0, Mem_Req},   {31'd0, r_req});
        check("we",     {31'd0, Mem_We},    {31'd0, r_we});
        check("addr",   Mem_Addr,           r_addr);
        check("wdata",  Mem_Wdata,          r_wdata);
        check("dout",   Data_Mem_Out,       r_dout);
        check("err",    {31'd0, Err},       {31'd0, r_err});
        check("stall",  {31'd0, Stall},     {31'd0, exp_stall()});
        check("bubble", {31'd0, Wb_Bubble}, {31'd0, exp_stall()});
        @(posedge CLK);
        model_edge();
    endtask

    task automatic idle_step();
        step(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    endtask

    initial begin
        // Reset held with a pending load: nothing may issue or stall.
        step(1, 1, 0, 32'h40, 32'h0, 0, 32'h0, 0);
        step(1, 1, 0, 32'h40, 32'h0, 0, 32'h0, 0);
        step(0, 1, 0, 32'h40, 32'h0, 0, 32'h0, 0);
        #1 check("rst_release_req", {31'd0, Mem_Req}, 32'd1);
        step(0, 1, 0, 32'h40, 32'h0, 1, 32'h5, 0);
        idle_step();

        // Zero-wait load.
        step(0, 1, 0, 32'h100, 32'h0, 0, 32'h0, 0);
        step(0, 1, 0, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0);
        #1 check("ld0_dout", Data_Mem_Out, 32'hDEADBEEF);
        idle_step();

        // Store acked on third WAIT cycle; read data must be ignored.
        step(0, 0, 1, 32'h200, 32'h12345678, 0, 32'h0, 0);
        step(0, 0, 1, 32'h200, 32'h12345678, 0, 32'h0, 0);
        step(0, 0, 1, 32'h200, 32'h12345678, 0, 32'h0, 0);
        #1 check("st_we", {31'd0, Mem_We}, 32'd1);
        step(0, 0, 1, 32'h200, 32'h12345678, 1, 32'hCAFEF00D, 0);
        #1 check("st_dout_kept", Data_Mem_Out, 32'hDEADBEEF);
        idle_step();

        // Timeout, then a normal op, then clear.
        step(0, 1, 0, 32'h300, 32'h0, 0, 32'h0, 0);
        for (int i = 0; i < TIMEOUT; i++) step(0, 1, 0, 32'h300, 32'h0, 0, 32'h0, 0);
        #1 check("to_err", {31'd0, Err}, 32'd1);
        check("to_dout", Data_Mem_Out, 32'h0);
        step(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
        step(0, 1, 0, 32'h304, 32'h0, 0, 32'h0, 0);
        step(0, 1, 0, 32'h304, 32'h0, 1, 32'hA5A5A5A5, 0);
        step(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1);
        #1 check("errclr", {31'd0, Err}, 32'd0);

        // Ack on the final timeout cycle, then spurious ack in IDLE.
        step(0, 1, 0, 32'h400, 32'h0, 0, 32'h0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) step(0, 1, 0, 32'h400, 32'h0, 0, 32'h0, 0);
        step(0, 1, 0, 32'h400, 32'h0, 1, 32'h0BADF00D, 0);
        #1 check("late_ack_err", {31'd0, Err}, 32'd0);
        check("late_ack_dout", Data_Mem_Out, 32'h0BADF00D);
        idle_step();
        step(0, 0, 0, 32'h0, 32'h0, 1, 32'h11111111, 0);
        step(0, 0, 0, 32'h0, 32'h0, 1, 32'h22222222, 0);

        // Reset during the second WAIT cycle, then a stale ack.
        step(0, 1, 0, 32'h500, 32'h0, 0, 32'h0, 0);
        step(0, 1, 0, 32'h500, 32'h0, 0, 32'h0, 0);
        step(1, 1, 0, 32'h500, 32'h0, 0, 32'h0, 0);
        #1 check("clr_req_drop", {31'd0, Mem_Req}, 32'd0);
        step(0, 0, 0, 32'h0, 32'h0, 1, 32'h33333333, 0);

        // Load and store together behave as a load.
        step(0, 1, 1, 32'h600, 32'h77777777, 0, 32'h0, 0);
        step(0, 1, 1, 32'h600, 32'h77777777, 1, 32'h44444444, 0);
        #1 check("ldst_dout", Data_Mem_Out, 32'h44444444);
        idle_step();

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 64) == 0,
                 ($urandom % 3) == 0,
                 ($urandom % 3) == 0,
                 $urandom, $urandom,
                 ($urandom % 10) < 3,
                 $urandom,
                 ($urandom % 16) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Sequences the MEM stage of the ARM pipeline around a variable-latency data memory with a req/ack interface. It detects a load or store leaving EX/MEM and issues the memory request. While the access is outstanding it stalls the upstream pipeline registers and forces a bubble into MEM/WB. When the access completes it presents the captured read data to MEM/WB for one cycle. A watchdog bounds every access and reports a sticky error when the memory fails to acknowledge.

## Interface
Parameters:
- TIMEOUT, 15, maximum WAIT cycles without ack before abort (1..255)
- CW, $clog2(TIMEOUT+1), timeout counter width (derived; not overridden)

Ports:
- CLK  input  1  pipeline clock; all state updates on rising edge
- CLR  input  1  reset; synchronous, active-high
- Load_In  input  1  EX/MEM load flag
- Store_In  input  1  EX/MEM store flag
- Addr_In  input  32  EX/MEM ALU result (effective address)
- Wdata_In  input  32  EX/MEM store data
- Err_Clr  input  1  clears sticky Err
- Mem_Ack  input  1  memory completion strobe, one cycle
- Mem_Rdata  input  32  memory read data, valid with Mem_Ack
- Mem_Req  output  1  registered; high for the whole outstanding access
- Mem_We  output  1  registered; 1 = store
- Mem_Addr  output  32  registered latched address
- Mem_Wdata  output  32  registered latched store data
- Stall  output  1  combinational; holds PC, IF/ID, ID/EX and EX/MEM
- Wb_Bubble  output  1  combinational; MEM/WB must capture Load=0, rf=0
- Data_Mem_Out  output  32  registered read data, fed to MEM/WB Data_Mem_In
- Err  output  1  registered sticky timeout flag

## Operation
- mem_op = Load_In | Store_In. If both are high, the access is treated as a load and Mem_We = 0.
- States: IDLE, WAIT, DONE. Encoding is free.
- IDLE:
  - If mem_op, latch Addr_In, Wdata_In and Store_In&~Load_In into Mem_Addr, Mem_Wdata and Mem_We.
  - Set Mem_Req = 1, clear the counter, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - Mem_Req stays 1; Mem_Addr, Mem_We and Mem_Wdata stay stable.
  - Mem_Ack = 1: Data_Mem_Out <= Mem_Rdata on a load (unchanged on a store), Mem_Req <= 0, go to DONE.
  - Else, if counter == TIMEOUT-1: Data_Mem_Out <= 0, Err <= 1, Mem_Req <= 0, go to DONE.
  - Else: counter increments.
  - Ack has priority over timeout in the same cycle.
- DONE: Stall = 0 and Wb_Bubble = 0, so EX/MEM and MEM/WB advance at the next edge. Always go to IDLE.
- Stall = Wb_Bubble = (IDLE & mem_op) | WAIT. Both are 0 in DONE and in IDLE without mem_op.
- A non-memory instruction in IDLE passes with Stall = 0 and Data_Mem_Out unchanged.
- Mem_Ack in IDLE or DONE is ignored and has no effect on any output.
- Err: set by timeout, cleared by Err_Clr. If both occur in the same cycle, set wins.
- Counter never exceeds TIMEOUT-1 and does not wrap.

## Timing
- Reset values while CLR is high: state IDLE, Mem_Req 0, Mem_We 0, Mem_Addr 0, Mem_Wdata 0, Data_Mem_Out 0, Err 0, counter 0. Stall and Wb_Bubble are forced to 0 while CLR is high.
- CLR asserted mid-access (WAIT or DONE): return to IDLE at that edge and drop Mem_Req the following cycle. A late Mem_Ack is then ignored.
- Edge numbering: mem_op is seen at edge 0 and Mem_Req rises after edge 0.
  - Ack in first WAIT cycle: DONE after edge 1, Stall high for 2 cycles, MEM/WB captures data at edge 2.
  - General: stall cycles = 2 + (WAIT cycles − 1).
  - Timeout: exactly TIMEOUT WAIT cycles, then DONE.
- Back-to-back memory ops: the next op is seen in IDLE the cycle after DONE. Minimum spacing is 3 cycles per access.
- Data_Mem_Out is valid in DONE and holds until the next load completion.

## Test plan
- Reset: hold CLR 2 cycles with Load_In=1 -> all outputs 0, Stall=0. Release CLR -> Mem_Req=1 one cycle later.
- Load, zero wait: Load_In=1, Addr_In=0x100, Mem_Ack the first WAIT cycle with Mem_Rdata=0xDEADBEEF -> Stall high 2 cycles, Mem_We=0, Mem_Addr=0x100, Data_Mem_Out=0xDEADBEEF in DONE.
- Store, 3-cycle wait: Store_In=1, Wdata_In=0x12345678, ack on the third WAIT cycle -> Mem_We=1, Mem_Wdata=0x12345678 stable throughout, Stall high 4 cycles, Data_Mem_Out unchanged.
- Timeout (TIMEOUT=4): load, never ack -> 4 WAIT cycles, then Err=1 and Data_Mem_Out=0. Next op proceeds normally. Err_Clr -> Err=0.
- Ack coincident with the final timeout cycle -> data captured, Err stays 0. Spurious Mem_Ack in IDLE -> no output change.
- CLR in the second WAIT cycle -> IDLE, Mem_Req=0 next cycle. Ack arriving after CLR -> ignored. Load+Store both high -> Mem_We=0.
